// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous single-port RAM.
// Each access runs IDLE -> ACC -> DONE, so the peak rate is one access every three cycles.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock_50_b7a,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e state_q, state_d;
  logic   owner_q;
  logic   last_q;
  logic   any_req;
  logic   winner;

  assign any_req = m0_req | m1_req;
  // On contention the requester not served last wins; otherwise whoever asks.
  assign winner  = (m0_req & m1_req) ? ~last_q : m1_req;

  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StAcc;
      StAcc:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operands are latched once at grant; later input changes are ignored.
  always_ff @(posedge clock_50_b7a) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            ram_addr  <= winner ? m1_addr  : m0_addr;
            ram_we    <= winner ? m1_we    : m0_we;
            ram_wdata <= winner ? m1_wdata : m0_wdata;
            owner_q   <= winner;
            last_q    <= winner;
          end
        end
        StAcc:   ram_we <= 1'b0;
        StDone:  ram_we <= 1'b0;
        default: ram_we <= 1'b0;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state_q == StDone) begin
      if (owner_q) begin
        m1_ack   = 1'b1;
        m1_rdata = ram_rdata;
      end else begin
        m0_ack   = 1'b1;
        m0_rdata = ram_rdata;
      end
    end
  end

endmodule
